m1_reader_cipher: RTL and testbench
===================================

M1_READER_CIPHER -- requirements
Module: m1_reader_cipher

Interface
REQ-001 sysclk  in  1  clock; all state changes on rising edge.
REQ-002 resetn  in  1  reset, asynchronous, active-low.
REQ-003 key  in  48  sector key; sampled when load_key=1.
REQ-004 load_key  in  1  load key into LFSR; honoured only in IDLE.
REQ-005 uid, nt, nr  in  32 each  card UID, tag nonce, reader nonce (plaintext); sampled when start_auth=1 in IDLE.
REQ-006 start_auth  in  1  begin authentication; honoured only in IDLE.
REQ-007 abort  in  1  synchronous return to IDLE from any state; LFSR kept.
REQ-008 in_byte  in  8; in_valid  in  1; in_ready  out  1  plaintext byte stream for STREAM state.
REQ-009 out_byte  out  8; out_par  out  1; out_valid  out  1; out_ready  in  1  encrypted byte plus encrypted parity.
REQ-010 busy  out  1  high in any state other than IDLE; auth_done  out  1  one-cycle pulse on INIT->NR-complete transition into STREAM.

Function
REQ-011 LFSR: 48 bits; linear feedback fb = XOR of bits 0,5,9,10,12,14,15,17,19,24,25,27,29,35,39,41,42,43; shift = {fb ^ in_bit, lfsr[47:1]}.
REQ-012 Key load order: lfsr = {key[7:0], key[15:8], key[23:16], key[31:24], key[39:32], key[47:40]}.
REQ-013 Keystream bit ks = m1filter output over odd LFSR bits 47,45,...,9 (MSB-first into the 20-bit filter input), evaluated on the current, unshifted state.
REQ-014 Word bit order: bytes most-significant first, bits within a byte LSB first (index sequence 24..31, 16..23, 8..15, 0..7).
REQ-015 FSM states: IDLE, INIT, NR_BIT, NR_PAR, NR_OUT, STREAM_IN, STREAM_BIT, STREAM_PAR, STREAM_OUT.
REQ-016 INIT: 32 cycles, one shift per cycle with in_bit = uid^nt bit; no output.
REQ-017 NR_BIT: 8 cycles per byte; in_bit = plaintext nr bit; ciphertext bit = nr bit ^ ks (ks taken before the shift); collected into out_byte.
REQ-018 NR_PAR/STREAM_PAR: 1 cycle, no shift; out_par = odd parity of plaintext byte ^ ks of current state.
REQ-019 NR_OUT/STREAM_OUT: out_valid=1, out_byte/out_par stable until out_valid&out_ready; then next byte, or after 4th nr byte -> STREAM_IN with auth_done pulse.
REQ-020 STREAM_IN: in_ready=1; on in_valid&in_ready capture byte -> STREAM_BIT (8 shifts, in_bit=0, ct bit = pt bit ^ ks) -> STREAM_PAR -> STREAM_OUT -> STREAM_IN.
REQ-021 Latency: start_auth accept to first out_valid = 32+8+1+1 = 42 cycles; stream byte accept to out_valid = 10 cycles.
REQ-022 Simultaneous load_key and start_auth in IDLE: key load wins; start_auth ignored.
REQ-023 abort asserted same cycle as any handshake: abort wins; no byte accepted or consumed; out_valid falls next cycle.
REQ-024 in_ready low outside STREAM_IN; out_valid low outside *_OUT states.

Reset
REQ-025 On resetn low: lfsr=0, state=IDLE, out_byte=0, out_par=0, out_valid=0, in_ready=0, busy=0, auth_done=0, bit counter=0, byte counter=0.
REQ-026 Reset mid-operation discards all progress; after release block sits in IDLE and requires load_key.

Structure
REQ-027 Shared package m1_pkg: LFSR width, feedback tap mask, key byte-swap function, FSM state enum, filter constants 0x9e98/0xb48e/0xec57e80a.
REQ-028 Single sub-module: existing m1filter instance for ks; no other hierarchy.

Verification
REQ-029 key=0, uid=nt=nr=0, start_auth -> four bytes 0x00 with out_par=1, auth_done pulse at cycle 42+3 handshakes, ks constantly 0.
REQ-030 Random key/uid/nt/nr vs bit-accurate C golden model of tag side -> tag model decrypts nr exactly, parity bits match model.
REQ-031 Stream 16 bytes 0x00..0x0F with random out_ready back-pressure -> ciphertext/parity equal to model, no byte lost or duplicated.
REQ-032 load_key and start_auth same cycle in IDLE -> LFSR equals byte-swapped key, busy stays 0.
REQ-033 abort in cycle 20 of INIT, then start_auth -> busy drops next cycle; second run continues from the 20-shift LFSR state per model.
REQ-034 resetn pulsed during STREAM_BIT -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/m1_pkg.sv
// Shared definitions for the MIFARE Classic (Crypto-1) reader-side cipher:
// LFSR geometry, feedback taps, filter lookup tables and the FSM state set.
package m1_pkg;

  localparam int LFSR_W = 48;

  // Taps 0,5,9,10,12,14,15,17,19,24,25,27,29,35,39,41,42,43
  localparam logic [LFSR_W-1:0] FB_MASK = 48'h0E882B0AD621;

  localparam logic [15:0] FA_LUT = 16'h9e98;
  localparam logic [15:0] FB_LUT = 16'hb48e;
  localparam logic [31:0] FC_LUT = 32'hec57e80a;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    NR_BIT,
    NR_PAR,
    NR_OUT,
    STREAM_IN,
    STREAM_BIT,
    STREAM_PAR,
    STREAM_OUT
  } state_t;

  // The key arrives little-endian by byte; the register wants byte 0 on top.
  function automatic logic [LFSR_W-1:0] key_swap(input logic [LFSR_W-1:0] key);
    return {key[7:0], key[15:8], key[23:16], key[31:24], key[39:32], key[47:40]};
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_shift(input logic [LFSR_W-1:0] s,
                                                   input logic in_bit);
    return {(^(s & FB_MASK)) ^ in_bit, s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/m1filter.sv
// Crypto-1 non-linear output filter: two-level table lookup over 20 LFSR taps.
module m1filter
  import m1_pkg::*;
(
  input  logic [19:0] x,
  output logic        ks
);

  logic [4:0] idx;

  always_comb begin
    idx = {FA_LUT[x[19:16]], FB_LUT[x[15:12]], FB_LUT[x[11:8]],
           FA_LUT[x[7:4]],   FB_LUT[x[3:0]]};
    ks  = FC_LUT[idx];
  end

endmodule

// File: rtl/m1_reader_cipher.sv
// Reader-side Crypto-1 engine: key load, uid^nt initialisation, encrypted
// reader nonce, then a byte-stream encryptor with encrypted odd parity.
module m1_reader_cipher
  import m1_pkg::*;
(
  input  logic        sysclk,
  input  logic        resetn,
  input  logic [47:0] key,
  input  logic        load_key,
  input  logic [31:0] uid,
  input  logic [31:0] nt,
  input  logic [31:0] nr,
  input  logic        start_auth,
  input  logic        abort,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_par,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        auth_done
);

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic [4:0]        bit_cnt_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       uid_nt_q;
  logic [31:0]       nr_q;
  logic [7:0]        pt_q;

  logic [19:0] filt_in;
  logic        ks;
  logic        init_bit;
  logic        nr_bit;
  logic [7:0]  nr_byte;

  always_comb begin
    for (int i = 0; i < 20; i++) filt_in[i] = lfsr_q[9 + 2*i];
  end

  m1filter u_filter (
    .x  (filt_in),
    .ks (ks)
  );

  // Words go out most-significant byte first, each byte LSB first.
  always_comb begin
    init_bit = uid_nt_q[{~bit_cnt_q[4:3], bit_cnt_q[2:0]}];
    nr_bit   = nr_q[{~byte_cnt_q, bit_cnt_q[2:0]}];
    nr_byte  = nr_q[{~byte_cnt_q, 3'b000} +: 8];
  end

  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (!load_key && start_auth) state_d = INIT;
        INIT:       if (bit_cnt_q == 5'd31) state_d = NR_BIT;
        NR_BIT:     if (bit_cnt_q[2:0] == 3'd7) state_d = NR_PAR;
        NR_PAR:     state_d = NR_OUT;
        NR_OUT:     if (out_ready) state_d = (byte_cnt_q == 2'd3) ? STREAM_IN : NR_BIT;
        STREAM_IN:  if (in_valid) state_d = STREAM_BIT;
        STREAM_BIT: if (bit_cnt_q[2:0] == 3'd7) state_d = STREAM_PAR;
        STREAM_PAR: state_d = STREAM_OUT;
        STREAM_OUT: if (out_ready) state_d = STREAM_IN;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    in_ready  = (state_q == STREAM_IN);
    out_valid = (state_q == NR_OUT) || (state_q == STREAM_OUT);
  end

  // Cipher state; abort freezes the LFSR where it stands.
  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q     <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      out_byte   <= '0;
      out_par    <= 1'b0;
      auth_done  <= 1'b0;
    end else begin
      auth_done <= 1'b0;
      if (!abort) begin
        case (state_q)
          IDLE: begin
            if (load_key) begin
              lfsr_q <= key_swap(key);
            end else if (start_auth) begin
              bit_cnt_q  <= '0;
              byte_cnt_q <= '0;
            end
          end
          INIT: begin
            lfsr_q    <= lfsr_shift(lfsr_q, init_bit);
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end
          NR_BIT: begin
            lfsr_q                    <= lfsr_shift(lfsr_q, nr_bit);
            out_byte[bit_cnt_q[2:0]]  <= nr_bit ^ ks;
            bit_cnt_q                 <= bit_cnt_q + 5'd1;
          end
          NR_PAR: begin
            out_par   <= ~(^nr_byte) ^ ks;
            bit_cnt_q <= '0;
          end
          NR_OUT: begin
            if (out_ready) begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              auth_done  <= (byte_cnt_q == 2'd3);
            end
          end
          STREAM_IN: begin
            if (in_valid) bit_cnt_q <= '0;
          end
          STREAM_BIT: begin
            lfsr_q                   <= lfsr_shift(lfsr_q, 1'b0);
            out_byte[bit_cnt_q[2:0]] <= pt_q[bit_cnt_q[2:0]] ^ ks;
            bit_cnt_q                <= bit_cnt_q + 5'd1;
          end
          STREAM_PAR: begin
            out_par   <= ~(^pt_q) ^ ks;
            bit_cnt_q <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (state_q == IDLE && start_auth && !load_key && !abort) begin
      uid_nt_q <= uid ^ nt;
      nr_q     <= nr;
    end
    if (state_q == STREAM_IN && in_valid && !abort) pt_q <= in_byte;
  end

endmodule

// File: tb/tb_m1_reader_cipher.sv
// Randomised scoreboard bench for m1_reader_cipher against a bit-serial
// Crypto-1 reference model (reader encrypts, tag side decrypts nr).
module tb_m1_reader_cipher;

  logic        sysclk = 1'b0;
  logic        resetn = 1'b0;
  logic [47:0] key = '0;
  logic        load_key = 1'b0;
  logic [31:0] uid = '0, nt = '0, nr = '0;
  logic        start_auth = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_par;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        auth_done;

  m1_reader_cipher dut (
    .sysclk     (sysclk),
    .resetn     (resetn),
    .key        (key),
    .load_key   (load_key),
    .uid        (uid),
    .nt         (nt),
    .nr         (nr),
    .start_auth (start_auth),
    .abort      (abort),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_byte   (out_byte),
    .out_par    (out_par),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .auth_done  (auth_done)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
  int auth_pulses = 0;

  typedef struct {
    logic [7:0]  ct;
    logic        par;
    logic        is_nr;
    logic [7:0]  pt;
    logic [47:0] tag_s;
  } exp_t;

  exp_t        sb[$];
  logic [47:0] m_lfsr = '0;

  localparam int TAPS [0:17] = '{0, 5, 9, 10, 12, 14, 15, 17, 19, 24, 25, 27, 29, 35, 39, 41, 42, 43};

  // ---------------- reference model ----------------
  function automatic logic m_feedback(input logic [47:0] s);
    logic f = 1'b0;
    for (int i = 0; i < 18; i++) f = f ^ s[TAPS[i]];
    return f;
  endfunction

  function automatic logic [47:0] m_step(input logic [47:0] s, input logic b);
    return {m_feedback(s) ^ b, s[47:1]};
  endfunction

  function automatic logic m_ks(input logic [47:0] s);
    logic [19:0] x;
    logic [15:0] fa_t, fb_t;
    logic [31:0] fc_t;
    int idx;
    fa_t = 16'h9e98;
    fb_t = 16'hb48e;
    fc_t = 32'hec57e80a;
    for (int i = 0; i < 20; i++) x[19 - i] = s[47 - 2*i];
    idx = 16 * int'(fa_t[x[19:16]]) + 8 * int'(fb_t[x[15:12]]) + 4 * int'(fb_t[x[11:8]])
        + 2 * int'(fa_t[x[7:4]]) + int'(fb_t[x[3:0]]);
    return fc_t[idx];
  endfunction

  function automatic int widx(input int k);
    return (3 - k / 8) * 8 + k % 8;
  endfunction

  function automatic logic [47:0] m_swap(input logic [47:0] k);
    logic [47:0] r;
    for (int i = 0; i < 6; i++) r[47 - 8*i -: 8] = k[8*i +: 8];
    return r;
  endfunction

  task automatic model_init(input logic [31:0] w, input int n);
    for (int k = 0; k < n; k++) m_lfsr = m_step(m_lfsr, w[widx(k)]);
  endtask

  task automatic model_byte(input logic [7:0] pt, input logic feed_pt, input logic is_nr);
    exp_t e;
    logic [7:0] ct;
    e.tag_s = m_lfsr;
    for (int j = 0; j < 8; j++) begin
      ct[j]  = pt[j] ^ m_ks(m_lfsr);
      m_lfsr = m_step(m_lfsr, feed_pt ? pt[j] : 1'b0);
    end
    e.ct    = ct;
    e.par   = (($countones(pt) % 2) == 0) ^ m_ks(m_lfsr);
    e.is_nr = is_nr;
    e.pt    = pt;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- out_ready driver ----------------
  always begin
    @(posedge sysclk);
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  exp_t        mon_e;
  logic [47:0] mon_s;
  logic [7:0]  mon_d;

  always @(negedge sysclk) begin
    if (auth_done) auth_pulses++;
    if (resetn && out_valid && out_ready && !abort) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", out_byte);
      end else begin
        mon_e = sb.pop_front();
        check("ct_byte", 64'(out_byte), 64'(mon_e.ct));
        check("ct_par", 64'(out_par), 64'(mon_e.par));
        if (mon_e.is_nr) begin
          mon_s = mon_e.tag_s;
          for (int j = 0; j < 8; j++) begin
            mon_d[j] = out_byte[j] ^ m_ks(mon_s);
            mon_s    = m_step(mon_s, mon_d[j]);
          end
          check("tag_nr_decrypt", 64'(mon_d), 64'(mon_e.pt));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_for(input int sel, input int limit, input string name, output int cyc);
    cyc = 1;
    forever begin
      @(negedge sysclk);
      if ((sel == 0 && out_valid) || (sel == 1 && in_ready)) break;
      cyc++;
      if (cyc > limit) begin
        checks++;
        errors++;
        $display("FAIL %s timeout actual=%0d cycles required<=%0d", name, cyc, limit);
        break;
      end
    end
  endtask

  task automatic do_load(input logic [47:0] k);
    key = k;
    load_key = 1'b1;
    tick();
    load_key = 1'b0;
    m_lfsr = m_swap(k);
  endtask

  task automatic run_auth(input logic [31:0] u, input logic [31:0] t, input logic [31:0] r);
    int lat, c, p0;
    p0 = auth_pulses;
    model_init(u ^ t, 32);
    for (int b = 0; b < 4; b++) model_byte(r[(3 - b) * 8 +: 8], 1'b1, 1'b1);
    uid = u; nt = t; nr = r;
    start_auth = 1'b1;
    tick();
    start_auth = 1'b0;
    wait_for(0, 100, "auth_latency", lat);
    check("auth_latency", 64'(lat), 64'd42);
    wait_for(1, 3000, "auth_to_stream", c);
    check("auth_done_on_stream_entry", 64'(auth_done), 64'd1);
    tick();
    check("auth_done_pulse_count", 64'(auth_pulses - p0), 64'd1);
  endtask

  task automatic stream_byte(input logic [7:0] pt);
    int lat, c;
    wait_for(1, 3000, "stream_ready", c);
    tick();
    model_byte(pt, 1'b0, 1'b0);
    in_byte = pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_for(0, 50, "stream_latency", lat);
    check("stream_latency", 64'(lat), 64'd10);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge sysclk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  task automatic go_idle();
    drain();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge sysclk);
    check("abort_busy_low", 64'(busy), 64'd0);
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [47:0] k;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_byte", 64'(out_byte), 64'd0);
    check("rst_out_par", 64'(out_par), 64'd0);
    check("rst_auth_done", 64'(auth_done), 64'd0);
    tick();
    resetn = 1'b1;
    m_lfsr = '0;
    tick();

    // All-zero key and nonces: keystream stays zero
    do_load(48'h0);
    run_auth(32'h0, 32'h0, 32'h0);
    stream_byte(8'h00);
    stream_byte(8'hA5);
    go_idle();

    // Random keys / nonces with back-pressure
    ready_mode = 1;
    for (int r = 0; r < 4; r++) begin
      do_load({16'($urandom), $urandom});
      run_auth($urandom, $urandom, $urandom);
      for (int i = 0; i < 3; i++) stream_byte(8'($urandom_range(0, 255)));
      go_idle();
    end

    // Sixteen-byte stream 0x00..0x0F
    do_load({16'($urandom), $urandom});
    run_auth($urandom, $urandom, $urandom);
    for (int i = 0; i < 16; i++) stream_byte(8'(i));
    go_idle();

    // load_key and start_auth together: key wins
    k = {16'($urandom), $urandom};
    key = k;
    uid = $urandom; nt = $urandom; nr = $urandom;
    load_key = 1'b1;
    start_auth = 1'b1;
    tick();
    load_key = 1'b0;
    start_auth = 1'b0;
    m_lfsr = m_swap(k);
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      check("load_wins_busy_low", 64'(busy), 64'd0);
    end
    check("load_wins_lfsr", 64'(dut.lfsr_q), 64'(m_swap(k)));
    tick();
    run_auth($urandom, $urandom, $urandom);
    stream_byte(8'h3C);
    go_idle();

    // Abort after 20 INIT shifts, then resume from that LFSR state
    do_load({16'($urandom), $urandom});
    uid = $urandom; nt = $urandom;
    start_auth = 1'b1;
    tick();
    start_auth = 1'b0;
    repeat (20) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    model_init(uid ^ nt, 20);
    @(negedge sysclk);
    check("init_abort_busy_low", 64'(busy), 64'd0);
    tick();
    run_auth($urandom, $urandom, $urandom);
    stream_byte(8'($urandom_range(0, 255)));
    go_idle();

    // Abort coinciding with an output handshake
    begin
      int c;
      ready_mode = 2;
      tick();
      start_auth = 1'b1;
      tick();
      start_auth = 1'b0;
      wait_for(0, 100, "abort_hs_wait", c);
      tick();
      abort = 1'b1;
      ready_mode = 0;
      tick();
      abort = 1'b0;
      @(negedge sysclk);
      check("abort_hs_out_valid_low", 64'(out_valid), 64'd0);
      check("abort_hs_busy_low", 64'(busy), 64'd0);
      ready_mode = 1;
      tick();
    end

    // Asynchronous reset during STREAM_BIT
    do_load({16'($urandom), $urandom});
    run_auth($urandom, $urandom, $urandom);
    drain();
    in_byte = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_byte", 64'(out_byte), 64'd0);
    check("arst_out_par", 64'(out_par), 64'd0);
    check("arst_auth_done", 64'(auth_done), 64'd0);
    tick();
    resetn = 1'b1;
    m_lfsr = '0;
    @(negedge sysclk);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd0);
    tick();

    // Without a key load the register starts from zero
    run_auth($urandom, $urandom, $urandom);
    stream_byte(8'h81);
    stream_byte(8'h7E);
    drain();

    repeat (5) @(negedge sysclk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
